fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Single owner of the trail framebuffer RAM write port (640x480 words of 8 bits; write clock CLOCK_50).
- Shares the port between two player drawing engines (player 1 and player 2).
- Runs a built-in clear sweeper that zero-fills the whole RAM after reset or on a restart request.
- Sits between the player modules and the RAM; the read side (VGA scan-out) is not touched.

Parameters:
- FB_WIDTH, 640, framebuffer width in pixels.
- FB_HEIGHT, 480, framebuffer height in pixels.
- ADDR_W, 19, write address width.
- DATA_W, 8, word width (trail colour code).
- CLEAR_VALUE, 8'h00, word written by the clear sweep.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- clear_start  in  1  one-cycle pulse: (re)start a full clear.
- p1_req  in  1  player 1 write request.
- p1_addr  in  ADDR_W  player 1 linear address (x + y*FB_WIDTH).
- p1_data  in  DATA_W  player 1 word.
- p1_gnt  out  1  player 1 request accepted this cycle.
- p2_req, p2_addr, p2_data, p2_gnt  same roles, player 2.
- wr_addr  out  ADDR_W  RAM wraddress.
- wr_data  out  DATA_W  RAM data.
- wren  out  1  RAM write enable.
- clear_busy  out  1  sweep in progress.
- clear_done  out  1  one-cycle pulse when the sweep finishes.
- conflict  out  1  one-cycle pulse: both players requested the same address in the same cycle.
- range_err  out  1  one-cycle pulse: a granted address was >= FB_WIDTH*FB_HEIGHT.

Behaviour:
- Reset (synchronous, active-high, CLOCK_50):
  - State goes to CLEAR; clear counter = 0.
  - wren = 0, wr_addr = 0, wr_data = 0, clear_done = 0, conflict = 0, range_err = 0.
  - clear_busy = 1.
- After reset deasserts, the clear sweep starts on the first edge.
- Two FSM states: CLEAR and RUN.
- CLEAR state:
  - Each cycle registers wren = 1, wr_addr = cnt, wr_data = CLEAR_VALUE, then cnt++.
  - Total 307200 writes (addresses 0..307199).
  - On the edge that issues address 307199, the next state is RUN.
  - clear_done pulses in the first RUN cycle; clear_busy drops to 0 in that same cycle.
  - p1_gnt = p2_gnt = 0 throughout CLEAR; requesters hold req.
- clear_start:
  - In either state, forces CLEAR with cnt = 0 on the next edge (a sweep already in progress restarts).
  - clear_start simultaneous with reset: reset wins, giving the same result.
- RUN state, grant logic (combinational, same cycle as req):
  - Only one requesting player: that player is granted.
  - Both requesting: round-robin. The player not granted last is granted; last_grant flips only on a dual-request grant.
  - last_grant resets to player 2, so player 1 wins the first tie.
  - A gnt means the request is consumed. The requester must drop req or present the next pixel on the following cycle.
- Write issue:
  - Registered: the winner's addr/data appear on wr_addr/wr_data with wren = 1 one cycle after gnt (latency 1).
  - A cycle with no grant gives wren = 0 next cycle; wr_addr/wr_data hold their last values.
- Range check:
  - Granted addr >= 307200: gnt is still asserted, the write is suppressed (wren = 0) and range_err pulses with the write slot.
- conflict:
  - Pulses, registered, when p1_req & p2_req & (p1_addr == p2_addr) in RUN.
  - The round-robin winner is written; the loser is granted on a later cycle if it keeps requesting.
- Back-to-back grants are allowed every cycle, giving up to one write per CLOCK_50 cycle.
- Widths:
  - Clear counter is 19 bits; the compare constant is FB_WIDTH*FB_HEIGHT-1.
  - No wrap: the counter stops at the last address.

Decomposition:
- Shared package fb_pkg:
  - FB_WIDTH, FB_HEIGHT, FB_WORDS = 307200, ADDR_W, DATA_W.
  - Trail colour codes: TRAIL_NONE = 8'h00, TRAIL_P1 = 8'h01, TRAIL_P2 = 8'h80.
  - State encoding typedef {CLEAR, RUN}.
- One natural sub-module: fb_clear_sweeper.
  - Contains the counter, busy and done logic.
  - Handshake with the parent: start in, addr out, valid out, done out.
  - The arbiter muxes its output onto the write port.

Test Plan:
1. Release reset, no requests -> exactly 307200 consecutive wren cycles covering addresses 0..307199 with data 0, then clear_done pulses once and clear_busy = 0.
2. RUN; p1_req with addr 153816 (x = 216, y = 240), data 8'h01 -> p1_gnt same cycle; next cycle wren = 1, wr_addr = 153816, wr_data = 8'h01.
3. RUN; p1 and p2 request continuously with distinct addresses -> grants alternate p1, p2, p1, p2 from reset; one write per cycle, each the granted player's addr/data.
4. Both request addr 1000 in the same cycle -> conflict pulses once; p1 is written first; p2 is granted the next cycle if it still requests.
5. p2_req with addr 307200 -> p2_gnt = 1, no wren next cycle, range_err pulses.
6. clear_start at cnt = 5000 during CLEAR, plus pending p1_req -> sweep restarts at address 0; p1_gnt stays 0 until clear_done; p1 is granted in the first RUN cycle.

Source files
------------

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared constants and types for the trail framebuffer write path.
//   - Framebuffer geometry (640x480 words, 19-bit linear address, 8-bit words)
//   - Trail colour codes written by the player engines and the clear sweep
//   - Arbiter state and player identifiers
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;   // 307200
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;

    localparam logic [DATA_W-1:0] TRAIL_NONE = 8'h00;
    localparam logic [DATA_W-1:0] TRAIL_P1   = 8'h01;
    localparam logic [DATA_W-1:0] TRAIL_P2   = 8'h80;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } fb_state_e;

    typedef enum logic {
        PLAYER_1 = 1'b0,
        PLAYER_2 = 1'b1
    } player_e;

endpackage : fb_pkg

// File: rtl/fb_clear_sweeper.sv
// -----------------------------------------------------------------------------
// fb_clear_sweeper
// Walks a linear address counter from 0 to WORDS-1, one address per cycle,
// so the parent can zero-fill the framebuffer.
//
// Ports:
//   CLOCK_50  in   system clock
//   reset     in   synchronous, active-high; arms a sweep from address 0
//   start     in   one-cycle pulse: restart the sweep from address 0
//   addr      out  address to write this cycle (valid while valid = 1)
//   valid     out  sweep in progress
//   last      out  this cycle presents the final address
//   done      out  one-cycle pulse on the cycle after the final address
// -----------------------------------------------------------------------------
module fb_clear_sweeper #(
    parameter int ADDR_W = 19,
    parameter int WORDS  = 307200
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              last,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // The counter parks on the last address rather than wrapping.
            if (cnt_q == LAST_ADDR) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign addr  = cnt_q;
    assign valid = busy_q;
    assign last  = busy_q && (cnt_q == LAST_ADDR);
    assign done  = done_q;

endmodule : fb_clear_sweeper

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
// Sole owner of the trail framebuffer RAM write port. After reset (or a
// clear_start pulse) it zero-fills the whole RAM, then shares the port between
// the two player drawing engines with round-robin arbitration. One write per
// cycle, issued one cycle after the grant.
//
// Ports:
//   CLOCK_50     in   system clock
//   reset        in   synchronous, active-high
//   clear_start  in   one-cycle pulse: (re)start a full clear
//   p1_req/p2_req    in   player write request
//   p1_addr/p2_addr  in   player linear address (x + y*FB_WIDTH)
//   p1_data/p2_data  in   player word
//   p1_gnt/p2_gnt    out  request consumed this cycle (combinational)
//   wr_addr      out  RAM write address
//   wr_data      out  RAM write data
//   wren         out  RAM write enable
//   clear_busy   out  clear sweep in progress
//   clear_done   out  one-cycle pulse when the sweep finishes
//   conflict     out  one-cycle pulse: both players asked for the same address
//   range_err    out  one-cycle pulse: a granted address was out of range
// -----------------------------------------------------------------------------
module fb_write_arbiter #(
    parameter int                FB_WIDTH    = 640,
    parameter int                FB_HEIGHT   = 480,
    parameter int                ADDR_W      = 19,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              clear_start,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_gnt,
    input  logic              p2_req,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_data,
    output logic              p2_gnt,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wren,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              conflict,
    output logic              range_err
);

    import fb_pkg::*;

    localparam int                WORDS   = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(WORDS);

    fb_state_e         state_q, state_d;
    player_e           last_grant_q, last_grant_d;

    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              conflict_q, conflict_d;
    logic              range_err_q, range_err_d;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic [ADDR_W-1:0] sweep_addr;
    logic              sweep_valid;
    logic              sweep_last;
    logic              sweep_done;

    fb_clear_sweeper #(
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS)
    ) u_sweeper (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (clear_start),
        .addr     (sweep_addr),
        .valid    (sweep_valid),
        .last     (sweep_last),
        .done     (sweep_done)
    );

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear_start overrides everything; the sweep hands over to
    // RUN on the edge that issues its final address.
    always_comb begin
        state_d = state_q;
        if (clear_start) begin
            state_d = CLEAR;
        end else if (state_q == CLEAR && sweep_last) begin
            state_d = RUN;
        end
    end

    // Outputs: grants plus the next contents of the registered write slot.
    always_comb begin
        p1_gnt       = 1'b0;
        p2_gnt       = 1'b0;
        last_grant_d = last_grant_q;
        wren_d       = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        conflict_d   = 1'b0;
        range_err_d  = 1'b0;
        sel_addr     = p1_addr;
        sel_data     = p1_data;

        if (clear_start) begin
            // Restart cycle: no grant is given, so no request is consumed
            // only to be erased by the sweep that follows.
            wren_d = 1'b0;
        end else if (state_q == CLEAR) begin
            wren_d    = sweep_valid;
            wr_addr_d = sweep_addr;
            wr_data_d = CLEAR_VALUE;
        end else begin
            conflict_d = p1_req && p2_req && (p1_addr == p2_addr);

            if (p1_req && p2_req) begin
                // Tie: the player not served by the last tie wins.
                if (last_grant_q == PLAYER_2) begin
                    p1_gnt       = 1'b1;
                    last_grant_d = PLAYER_1;
                end else begin
                    p2_gnt       = 1'b1;
                    last_grant_d = PLAYER_2;
                end
            end else begin
                p1_gnt = p1_req;
                p2_gnt = p2_req;
            end

            if (p2_gnt) begin
                sel_addr = p2_addr;
                sel_data = p2_data;
            end

            if (p1_gnt || p2_gnt) begin
                if (sel_addr < WORDS_A) begin
                    wren_d    = 1'b1;
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
                end else begin
                    range_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            last_grant_q <= PLAYER_2;
            wren_q       <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            conflict_q   <= 1'b0;
            range_err_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            wren_q       <= wren_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            conflict_q   <= conflict_d;
            range_err_q  <= range_err_d;
        end
    end

    assign wren       = wren_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign conflict   = conflict_q;
    assign range_err  = range_err_q;
    assign clear_busy = sweep_valid;
    assign clear_done = sweep_done;

endmodule : fb_write_arbiter

// File: tb/tb_fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_write_arbiter
// Self-checking bench for fb_write_arbiter. A reduced 64x48 geometry keeps each
// full clear sweep short; the arbitration and write path are geometry-neutral.
// Expected write slots are pushed to a queue when a cycle is driven and popped
// when the DUT presents that slot.
// -----------------------------------------------------------------------------
module tb_fb_write_arbiter;

    import fb_pkg::*;

    localparam int TB_W     = 64;
    localparam int TB_H     = 48;
    localparam int TB_WORDS = TB_W * TB_H;
    localparam int TB_AW    = 19;
    localparam int TB_DW    = 8;

    typedef struct {
        logic             wren;
        logic [TB_AW-1:0] addr;
        logic [TB_DW-1:0] data;
        logic             range_err;
        logic             conflict;
    } exp_t;

    logic             CLOCK_50 = 1'b0;
    logic             reset;
    logic             clear_start;
    logic             p1_req, p2_req;
    logic [TB_AW-1:0] p1_addr, p2_addr;
    logic [TB_DW-1:0] p1_data, p2_data;
    logic             p1_gnt, p2_gnt;
    logic [TB_AW-1:0] wr_addr;
    logic [TB_DW-1:0] wr_data;
    logic             wren, clear_busy, clear_done, conflict, range_err;

    int               tests  = 0;
    int               failed = 0;
    exp_t             exp_q[$];
    player_e          m_last;
    logic [TB_AW-1:0] m_addr;
    logic [TB_DW-1:0] m_data;

    fb_write_arbiter #(
        .FB_WIDTH    (TB_W),
        .FB_HEIGHT   (TB_H),
        .ADDR_W      (TB_AW),
        .DATA_W      (TB_DW),
        .CLEAR_VALUE (TRAIL_NONE)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .clear_start (clear_start),
        .p1_req      (p1_req),
        .p1_addr     (p1_addr),
        .p1_data     (p1_data),
        .p1_gnt      (p1_gnt),
        .p2_req      (p2_req),
        .p2_addr     (p2_addr),
        .p2_data     (p2_data),
        .p2_gnt      (p2_gnt),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wren        (wren),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .conflict    (conflict),
        .range_err   (range_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2ms;
        $display("FAIL watchdog: got no summary, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1. Verifies a complete sweep from address 0; when
    // p1_pending is set, player 1 must stay ungranted until the first RUN cycle.
    task automatic run_sweep(input string tag, input logic p1_pending);
        int  good   = 0;
        int  waited = 0;
        logic last;
        @(posedge CLOCK_50); #1;
        while (!(wren === 1'b1 && wr_addr === '0) && waited < 4) begin
            if (p1_gnt !== 1'b0) good--;
            @(posedge CLOCK_50); #1;
            waited++;
        end
        check({tag, "_start"}, {31'd0, wren === 1'b1 && wr_addr === '0}, 32'd1);
        for (int i = 0; i < TB_WORDS; i++) begin
            if (i > 0) begin
                @(posedge CLOCK_50); #1;
            end
            last = (i == TB_WORDS - 1);
            if (wren === 1'b1 && wr_addr === TB_AW'(i) && wr_data === TRAIL_NONE &&
                clear_busy === !last && clear_done === last &&
                p1_gnt === (p1_pending && last) && p2_gnt === 1'b0)
                good++;
        end
        check({tag, "_writes"}, good, TB_WORDS);
        m_addr = TB_AW'(TB_WORDS - 1);
        m_data = TRAIL_NONE;
    endtask

    // Called at posedge+1: drive one RUN cycle, check grants, queue the
    // expected write slot and compare it one edge later.
    task automatic play(input logic r1, input logic [TB_AW-1:0] a1, input logic [TB_DW-1:0] d1,
                        input logic r2, input logic [TB_AW-1:0] a2, input logic [TB_DW-1:0] d2);
        logic g1, g2;
        exp_t e, o;
        p1_req = r1; p1_addr = a1; p1_data = d1;
        p2_req = r2; p2_addr = a2; p2_data = d2;
        if (r1 && r2) begin
            g1     = (m_last == PLAYER_2);
            g2     = !g1;
            m_last = g1 ? PLAYER_1 : PLAYER_2;
        end else begin
            g1 = r1;
            g2 = r2;
        end
        @(negedge CLOCK_50);
        check("p1_gnt", {31'd0, p1_gnt}, {31'd0, g1});
        check("p2_gnt", {31'd0, p2_gnt}, {31'd0, g2});
        e.conflict  = r1 && r2 && (a1 == a2);
        e.range_err = 1'b0;
        e.wren      = 1'b0;
        if (g1 || g2) begin
            if ((g1 ? a1 : a2) < TB_AW'(TB_WORDS)) begin
                e.wren = 1'b1;
                m_addr = g1 ? a1 : a2;
                m_data = g1 ? d1 : d2;
            end else begin
                e.range_err = 1'b1;
            end
        end
        e.addr = m_addr;
        e.data = m_data;
        exp_q.push_back(e);
        @(posedge CLOCK_50); #1;
        o = exp_q.pop_front();
        check("wren",      {31'd0, wren},      {31'd0, o.wren});
        check("wr_addr",   {13'd0, wr_addr},   {13'd0, o.addr});
        check("wr_data",   {24'd0, wr_data},   {24'd0, o.data});
        check("range_err", {31'd0, range_err}, {31'd0, o.range_err});
        check("conflict",  {31'd0, conflict},  {31'd0, o.conflict});
    endtask

    initial begin
        int waited;
        m_last      = PLAYER_2;
        reset       = 1'b1;
        clear_start = 1'b1;     // reset must win over a simultaneous restart
        p1_req = 1'b1; p1_addr = '0; p1_data = '0;
        p2_req = 1'b0; p2_addr = '0; p2_data = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_wren",       {31'd0, wren},       32'd0);
        check("rst_wr_addr",    {13'd0, wr_addr},    32'd0);
        check("rst_wr_data",    {24'd0, wr_data},    32'd0);
        check("rst_clear_busy", {31'd0, clear_busy}, 32'd1);
        check("rst_clear_done", {31'd0, clear_done}, 32'd0);
        check("rst_conflict",   {31'd0, conflict},   32'd0);
        check("rst_range_err",  {31'd0, range_err},  32'd0);
        check("rst_p1_gnt",     {31'd0, p1_gnt},     32'd0);
        clear_start = 1'b0;
        p1_req      = 1'b0;
        reset       = 1'b0;

        // Initial zero-fill after reset.
        run_sweep("sweep0", 1'b0);
        play(1'b0, '0, '0, 1'b0, '0, '0);
        check("done_once",  {31'd0, clear_done}, 32'd0);
        check("busy_low",   {31'd0, clear_busy}, 32'd0);

        // Single requester at (x=21, y=24).
        play(1'b1, TB_AW'(21 + 24 * TB_W), TRAIL_P1, 1'b0, '0, '0);

        // Continuous dual requests, distinct addresses: p1, p2, p1, p2.
        for (int k = 0; k < 4; k++)
            play(1'b1, TB_AW'(100 + k), TRAIL_P1, 1'b1, TB_AW'(200 + k), TRAIL_P2);

        // Lone p2 after the ties does not disturb round-robin history.
        play(1'b0, '0, '0, 1'b1, TB_AW'(300), TRAIL_P2);

        // Same address from both players: conflict, p1 first, then p2.
        play(1'b1, TB_AW'(1000), TRAIL_P1, 1'b1, TB_AW'(1000), TRAIL_P2);
        play(1'b0, '0, '0, 1'b1, TB_AW'(1000), TRAIL_P2);

        // Out-of-range grant: consumed, write suppressed, range_err pulses.
        play(1'b0, '0, '0, 1'b1, TB_AW'(TB_WORDS), TRAIL_P2);
        play(1'b0, '0, '0, 1'b0, '0, '0);

        // Restart from RUN, then restart again mid-sweep with p1 pending.
        p1_req = 1'b0; p2_req = 1'b0;
        clear_start = 1'b1;
        @(posedge CLOCK_50); #1;
        clear_start = 1'b0;
        check("restart_busy", {31'd0, clear_busy}, 32'd1);
        waited = 0;
        while (!(wren === 1'b1 && wr_addr === TB_AW'(999)) && waited < 2000) begin
            @(posedge CLOCK_50); #1;
            waited++;
        end
        check("reach_999", {31'd0, wren === 1'b1 && wr_addr === TB_AW'(999)}, 32'd1);
        p1_req = 1'b1; p1_addr = TB_AW'(2000); p1_data = TRAIL_P1;
        clear_start = 1'b1;
        @(negedge CLOCK_50);
        check("clear_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        @(posedge CLOCK_50); #1;
        clear_start = 1'b0;
        run_sweep("sweep1", 1'b1);
        // First RUN cycle: pending p1 is granted and written next.
        play(1'b1, TB_AW'(2000), TRAIL_P1, 1'b0, '0, '0);
        play(1'b0, '0, '0, 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_fb_write_arbiter
